// File: rtl/bxu_prog_loader.sv
// bxu_prog_loader: loads BXU instruction memory from a length-prefixed byte
// stream. The stream is N (16-bit, low byte first) followed by N words, each
// sent low byte then high byte. Each word goes to the next address, starting
// at 0.
// Optional feature macro: BXU_LOADER_CHECKSUM_EN. When it is defined, one
// trailing byte holds the XOR of all earlier stream bytes, and `err` flags a
// mismatch.
// Handshake: a byte moves on a rising edge where in_valid & in_ready.
// in_ready comes straight from a register that is loaded from the next
// state, so it never depends combinationally on in_valid. While in_valid is
// low the FSM holds its state and nothing else changes.
module bxu_prog_loader #(
    parameter int ADDR_BITWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_BITWIDTH-1:0] mem_addr,
    output logic [15:0]              mem_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DAT_LO = 3'd3,
        S_DAT_HI = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

`ifdef BXU_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      state;
    state_t      next_state;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [7:0]  lo_q;
    logic        xfer;
    logic        start_load;

    assign xfer       = in_valid & in_ready;
    assign start_load = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign dbg_state  = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every move except a start needs a byte transfer
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    next_state = ({in_data, len_q[7:0]} == 16'd0) ? S_END : S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (xfer) next_state = S_DAT_HI;
            end
            S_DAT_HI: begin
                if (xfer) begin
                    next_state = ((idx_q + 16'd1) == len_q) ? S_END : S_DAT_LO;
                end
            end
            S_CHK: begin
                if (xfer) next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs, registered from the next state so they change with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (next_state != S_IDLE) && (next_state != S_DONE);
            busy     <= (next_state != S_IDLE) && (next_state != S_DONE);
            done     <= (next_state == S_DONE);
        end
    end

    // Length capture, word assembly and the one-cycle memory write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= 16'd0;
            idx_q    <= 16'd0;
            lo_q     <= 8'd0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= 16'd0;
        end else begin
            mem_we <= 1'b0;
            if (start_load) begin
                idx_q <= 16'd0;
            end else if (xfer) begin
                case (state)
                    S_LEN_LO: len_q[7:0]  <= in_data;
                    S_LEN_HI: len_q[15:8] <= in_data;
                    S_DAT_LO: lo_q        <= in_data;
                    S_DAT_HI: begin
                        mem_we   <= 1'b1;
                        mem_addr <= idx_q[ADDR_BITWIDTH-1:0];
                        mem_data <= {in_data, lo_q};
                        idx_q    <= idx_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BXU_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       err_q;

    // XOR running sum of length/data bytes; the CHK byte is compared against it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
            err_q  <= 1'b0;
        end else if (start_load) begin
            csum_q <= 8'd0;
            err_q  <= 1'b0;
        end else if (xfer) begin
            if (state == S_CHK) begin
                err_q <= (in_data != csum_q);
            end else begin
                csum_q <= csum_q ^ in_data;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bxu_prog_loader.sv
// Bench for bxu_prog_loader. Two instances share every input: one uses the
// default 16-bit address and the other uses a 2-bit address to exercise
// address wrap. Expected writes go into queues when a word is sent; a
// monitor pops and compares on every mem_we.
module tb_bxu_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready,  mem_we,  busy,  done,  err;
    logic [15:0] mem_addr,  mem_data;
    logic [2:0]  dbg_state;
    logic        in_ready2, mem_we2, busy2, done2, err2;
    logic [1:0]  mem_addr2;
    logic [15:0] mem_data2;
    logic [2:0]  dbg_state2;

    int          tests = 0;
    int          fails = 0;
    int          we_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];
    logic [15:0] words[$];
    logic [7:0]  csum;

    // clock / reset
    always #5 clk = ~clk;

    bxu_prog_loader #(.ADDR_BITWIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
        .err(err), .dbg_state(dbg_state)
    );

    bxu_prog_loader #(.ADDR_BITWIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .busy(busy2), .done(done2),
        .err(err2), .dbg_state(dbg_state2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bit ok;
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        in_valid = 1'b1;
        in_data  = b;
        csum     = csum ^ b;
        waited   = 0;
        ok       = 1'b0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load(input int gap_max, input bit good_csum, input int mid_start);
        int          n;
        logic [15:0] a2;
        logic [7:0]  c;
        logic        exp_err;
        n = words.size();
        pulse_start();
        check("start_busy_ready", {30'd0, busy, in_ready}, 32'd3);
        csum = 8'd0;
        send_byte(n[7:0], $urandom_range(0, gap_max));
        send_byte(n[15:8], $urandom_range(0, gap_max));
        for (int i = 0; i < n; i++) begin
            if (i == mid_start) begin
                pulse_start();
                check("mid_start_ignored", {31'd0, busy}, 32'd1);
            end
            a2 = 16'(i % 4);
            exp_q.push_back({i[15:0], words[i]});
            exp2_q.push_back({a2, words[i]});
            send_byte(words[i][7:0], $urandom_range(0, gap_max));
            send_byte(words[i][15:8], $urandom_range(0, gap_max));
        end
`ifdef BXU_LOADER_CHECKSUM_EN
        c = good_csum ? csum : (csum ^ 8'h5A);
        send_byte(c, $urandom_range(0, gap_max));
        exp_err = !good_csum;
`else
        c = csum;
        exp_err = 1'b0;
`endif
        check("end_done_busy_ready_err", {28'd0, done, busy, in_ready, err},
              {28'd0, 1'b1, 1'b0, 1'b0, exp_err});
        check("end_dut2_status", {28'd0, done2, busy2, in_ready2, err2},
              {28'd0, 1'b1, 1'b0, 1'b0, exp_err});
        @(posedge clk);
        #1;
        check("queue_drained", exp_q.size() + exp2_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check(name, {23'd0, in_ready, mem_we, busy, done, err, dbg_state}, 32'd0);
        check({name, "_bus"}, {mem_addr, mem_data}, 32'd0);
        check({name, "_dut2"}, {7'd0, in_ready2, mem_we2, busy2, done2, err2,
              dbg_state2, mem_addr2, mem_data2}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        csum     = 8'd0;

        // scoreboard monitor
        fork
            forever begin
                @(negedge clk);
                if (mem_we) begin
                    we_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got 0x%0h expected none", {mem_addr, mem_data});
                    end else begin
                        check("write", {mem_addr, mem_data}, exp_q.pop_front());
                    end
                end
                if (mem_we2) begin
                    if (exp2_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write2: got 0x%0h expected none", {14'd0, mem_addr2, mem_data2});
                    end else begin
                        check("write2", {14'd0, mem_addr2, mem_data2}, exp2_q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic 7-word program, back-to-back bytes
        words = '{16'h000B, 16'h0012, 16'h0016, 16'h0012, 16'h8016, 16'h2003, 16'h0203};
        we_cnt = 0;
        load(0, 1'b1, -1);
        check("we_count_basic", we_cnt, 32'd7);

        // same program with random valid gaps
        we_cnt = 0;
        load(3, 1'b1, -1);
        check("we_count_gaps", we_cnt, 32'd7);

        // empty program
        words = {};
        we_cnt = 0;
        load(0, 1'b1, -1);
        check("we_count_empty", we_cnt, 32'd0);

        // single word, good then bad checksum
        words = '{16'h1234};
        load(0, 1'b1, -1);
        load(0, 1'b0, -1);

        // reset after three of seven words, then a full reload
        words = '{16'h000B, 16'h0012, 16'h0016, 16'h0012, 16'h8016, 16'h2003, 16'h0203};
        pulse_start();
        csum = 8'd0;
        send_byte(8'h07, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({i[15:0], words[i]});
            exp2_q.push_back({16'(i % 4), words[i]});
            send_byte(words[i][7:0], 0);
            send_byte(words[i][15:8], 0);
        end
        @(posedge clk);
        #1;
        check("partial_drained", exp_q.size() + exp2_q.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_values("midload_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        we_cnt = 0;
        load(1, 1'b1, -1);
        check("we_count_reload", we_cnt, 32'd7);

        // five words: the narrow instance wraps, and a start mid-load is ignored
        words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        we_cnt = 0;
        load(0, 1'b1, 2);
        check("we_count_wrap", we_cnt, 32'd5);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
